// File: rtl/audio_seq_ctrl.sv
// Record/playback sequencer: brings up the audio codec with bounded retries,
// then arbitrates record, play, pause and stop keys over one sample buffer.
module audio_seq_ctrl #(
  parameter int ADDR_W       = 20,
  parameter int INIT_TIMEOUT = 1048576,
  parameter int MAX_RETRY    = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic              i_init_finished,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic              o_init_start,
  output logic              o_rec_en,
  output logic              o_rec_clr,
  output logic              o_play_en,
  output logic              o_play_clr,
  output logic              o_play_done,
  output logic [ADDR_W-1:0] o_rec_len,
  output logic [2:0]        o_state,
  output logic              o_error
);

  localparam int TO_W = (INIT_TIMEOUT > 2) ? $clog2(INIT_TIMEOUT) : 1;
  localparam int RT_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  // The timeout fires as the counter steps onto INIT_TIMEOUT-1, so successive
  // init attempts start exactly INIT_TIMEOUT cycles apart.
  localparam logic [TO_W-1:0] TO_FIRE    = TO_W'(INIT_TIMEOUT - 2);
  localparam logic [RT_W-1:0] RETRY_LAST = RT_W'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    INIT_REQ   = 3'd0,
    INIT_WAIT  = 3'd1,
    IDLE       = 3'd2,
    REC        = 3'd3,
    REC_PAUSE  = 3'd4,
    PLAY       = 3'd5,
    PLAY_PAUSE = 3'd6,
    ERROR      = 3'd7
  } state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [RT_W-1:0] retry_cnt;

  assign o_state = state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= INIT_REQ;
      to_cnt       <= '0;
      retry_cnt    <= '0;
      o_init_start <= 1'b0;
      o_rec_en     <= 1'b0;
      o_rec_clr    <= 1'b0;
      o_play_en    <= 1'b0;
      o_play_clr   <= 1'b0;
      o_play_done  <= 1'b0;
      o_rec_len    <= '0;
      o_error      <= 1'b0;
    end else begin
      o_init_start <= 1'b0;
      o_rec_clr    <= 1'b0;
      o_play_clr   <= 1'b0;
      o_play_done  <= 1'b0;
      case (state)
        INIT_REQ: begin
          o_init_start <= 1'b1;
          to_cnt       <= '0;
          state        <= INIT_WAIT;
        end
        INIT_WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (i_init_finished) begin
            state <= IDLE;
          end else if (to_cnt == TO_FIRE) begin
            if (retry_cnt == RETRY_LAST) begin
              state   <= ERROR;
              o_error <= 1'b1;
            end else begin
              state <= INIT_REQ;
            end
            if (retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (i_key_rec) begin
            o_rec_clr <= 1'b1;
            o_rec_len <= '0;
            o_rec_en  <= 1'b1;
            state     <= REC;
          end else if (i_key_play && (o_rec_len != '0)) begin
            o_play_clr <= 1'b1;
            o_play_en  <= 1'b1;
            state      <= PLAY;
          end
        end
        REC: begin
          // A full buffer ends the take exactly like a stop key.
          if (i_key_stop || (i_rec_addr == '1)) begin
            o_rec_len <= i_rec_addr;
            o_rec_en  <= 1'b0;
            state     <= IDLE;
          end else if (i_key_pause) begin
            o_rec_en <= 1'b0;
            state    <= REC_PAUSE;
          end
        end
        REC_PAUSE: begin
          if (i_key_stop) begin
            o_rec_len <= i_rec_addr;
            state     <= IDLE;
          end else if (i_key_pause || i_key_rec) begin
            o_rec_en <= 1'b1;
            state    <= REC;
          end
        end
        PLAY: begin
          if (i_key_stop) begin
            o_play_en <= 1'b0;
            state     <= IDLE;
          end else if (i_play_addr >= o_rec_len) begin
            o_play_done <= 1'b1;
            o_play_en   <= 1'b0;
            state       <= IDLE;
          end else if (i_key_pause) begin
            o_play_en <= 1'b0;
            state     <= PLAY_PAUSE;
          end
        end
        PLAY_PAUSE: begin
          if (i_key_stop) begin
            state <= IDLE;
          end else if (i_key_pause || i_key_play) begin
            o_play_en <= 1'b1;
            state     <= PLAY;
          end
        end
        ERROR: begin
          o_error   <= 1'b1;
          o_rec_en  <= 1'b0;
          o_play_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_seq_ctrl.sv
// Bench for audio_seq_ctrl: directed scenarios with literal expectations, then
// randomized keys and addresses checked every cycle against a mode-level model.
module tb_audio_seq_ctrl;

  localparam int ADDR_W       = 8;
  localparam int INIT_TIMEOUT = 16;
  localparam int MAX_RETRY    = 3;
  localparam int ALL_ONES     = (1 << ADDR_W) - 1;

  localparam int M_INIT_REQ   = 0;
  localparam int M_INIT_WAIT  = 1;
  localparam int M_IDLE       = 2;
  localparam int M_REC        = 3;
  localparam int M_REC_PAUSE  = 4;
  localparam int M_PLAY       = 5;
  localparam int M_PLAY_PAUSE = 6;
  localparam int M_ERROR      = 7;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_key_rec, i_key_play, i_key_pause, i_key_stop;
  logic              i_init_finished;
  logic [ADDR_W-1:0] i_rec_addr, i_play_addr;
  logic              o_init_start, o_rec_en, o_rec_clr, o_play_en, o_play_clr, o_play_done;
  logic [ADDR_W-1:0] o_rec_len;
  logic [2:0]        o_state;
  logic              o_error;

  int errors, checks, cyc, pulse_cnt;
  int pulse_cyc [8];

  always #5 i_clk = ~i_clk;

  audio_seq_ctrl #(
    .ADDR_W(ADDR_W), .INIT_TIMEOUT(INIT_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_key_rec(i_key_rec), .i_key_play(i_key_play),
    .i_key_pause(i_key_pause), .i_key_stop(i_key_stop),
    .i_init_finished(i_init_finished),
    .i_rec_addr(i_rec_addr), .i_play_addr(i_play_addr),
    .o_init_start(o_init_start), .o_rec_en(o_rec_en), .o_rec_clr(o_rec_clr),
    .o_play_en(o_play_en), .o_play_clr(o_play_clr), .o_play_done(o_play_done),
    .o_rec_len(o_rec_len), .o_state(o_state), .o_error(o_error)
  );

  // Mode-level model: m_age counts cycles since the init pulse became visible.
  int m_mode = 0, m_age = 0, m_attempts = 0, m_rec_len = 0;
  bit m_init_start = 0, m_rec_clr = 0, m_play_clr = 0, m_done = 0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_mode = M_INIT_REQ; m_age = 0; m_attempts = 0; m_rec_len = 0;
      m_init_start = 0; m_rec_clr = 0; m_play_clr = 0; m_done = 0;
    end else begin
      m_init_start = 0; m_rec_clr = 0; m_play_clr = 0; m_done = 0;
      case (m_mode)
        M_INIT_REQ: begin m_init_start = 1; m_age = 1; m_mode = M_INIT_WAIT; end
        M_INIT_WAIT:
          if (i_init_finished) m_mode = M_IDLE;
          else if (m_age == INIT_TIMEOUT - 1) begin
            m_attempts++;
            m_mode = (m_attempts >= MAX_RETRY) ? M_ERROR : M_INIT_REQ;
          end else m_age++;
        M_IDLE:
          if (i_key_rec) begin m_rec_clr = 1; m_rec_len = 0; m_mode = M_REC; end
          else if (i_key_play && m_rec_len != 0) begin m_play_clr = 1; m_mode = M_PLAY; end
        M_REC:
          if (i_key_stop || int'(i_rec_addr) == ALL_ONES) begin
            m_rec_len = int'(i_rec_addr); m_mode = M_IDLE;
          end else if (i_key_pause) m_mode = M_REC_PAUSE;
        M_REC_PAUSE:
          if (i_key_stop) begin m_rec_len = int'(i_rec_addr); m_mode = M_IDLE; end
          else if (i_key_pause || i_key_rec) m_mode = M_REC;
        M_PLAY:
          if (i_key_stop) m_mode = M_IDLE;
          else if (int'(i_play_addr) >= m_rec_len) begin m_done = 1; m_mode = M_IDLE; end
          else if (i_key_pause) m_mode = M_PLAY_PAUSE;
        M_PLAY_PAUSE:
          if (i_key_stop) m_mode = M_IDLE;
          else if (i_key_pause || i_key_play) m_mode = M_PLAY;
        default: ;
      endcase
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic compareAll();
    checkOutput("state",      o_state,      m_mode);
    checkOutput("init_start", o_init_start, m_init_start);
    checkOutput("rec_en",     o_rec_en,     m_mode == M_REC);
    checkOutput("play_en",    o_play_en,    m_mode == M_PLAY);
    checkOutput("rec_clr",    o_rec_clr,    m_rec_clr);
    checkOutput("play_clr",   o_play_clr,   m_play_clr);
    checkOutput("play_done",  o_play_done,  m_done);
    checkOutput("rec_len",    o_rec_len,    m_rec_len);
    checkOutput("error",      o_error,      m_mode == M_ERROR);
    checkOutput("exclusive_en", o_rec_en & o_play_en, 0);
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
    if (o_init_start) begin
      if (pulse_cnt < 8) pulse_cyc[pulse_cnt] = cyc;
      pulse_cnt++;
    end
    compareAll();
  endtask

  task automatic applyStimulus(input bit rec, input bit play, input bit pause,
                               input bit stop, input bit fin);
    i_key_rec = rec; i_key_play = play; i_key_pause = pause; i_key_stop = stop;
    i_init_finished = fin;
    tick();
    i_key_rec = 0; i_key_play = 0; i_key_pause = 0; i_key_stop = 0; i_init_finished = 0;
  endtask

  task automatic bringUp();
    #2 i_rst_n = 0;
    tick();
    i_rst_n = 1;
    tick();
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; pulse_cnt = 0;
    i_rst_n = 0;
    i_key_rec = 0; i_key_play = 0; i_key_pause = 0; i_key_stop = 0; i_init_finished = 0;
    i_rec_addr = '0; i_play_addr = '0;
    repeat (2) @(negedge i_clk);
    checkOutput("reset_state", o_state, 0);
    checkOutput("reset_init_start", o_init_start, 0);
    checkOutput("reset_rec_len", o_rec_len, 0);
    checkOutput("reset_error", o_error, 0);
    compareAll();

    // Codec never answers: three attempts, then a sticky error that ignores keys.
    i_rst_n = 1;
    tick();
    checkOutput("first_edge_init_start", o_init_start, 1);
    checkOutput("first_edge_state", o_state, 1);
    for (int i = 0; i < 70; i++) begin
      i_key_rec = ($urandom_range(0, 3) == 0); i_key_play = ($urandom_range(0, 3) == 0);
      i_key_pause = ($urandom_range(0, 3) == 0); i_key_stop = ($urandom_range(0, 3) == 0);
      tick();
    end
    i_key_rec = 0; i_key_play = 0; i_key_pause = 0; i_key_stop = 0;
    checkOutput("retry_pulses", pulse_cnt, 3);
    checkOutput("retry_gap1", pulse_cyc[1] - pulse_cyc[0], 16);
    checkOutput("retry_gap2", pulse_cyc[2] - pulse_cyc[1], 16);
    checkOutput("error_state", o_state, 7);
    checkOutput("error_flag", o_error, 1);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("error_keys_state", o_state, 7);
    checkOutput("error_keys_rec_en", o_rec_en, 0);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("error_keys_state2", o_state, 7);

    // Codec answers 10 cycles after the init pulse.
    #2 i_rst_n = 0;
    tick();
    i_rst_n = 1;
    pulse_cnt = 0;
    tick();
    repeat (9) tick();
    checkOutput("init_wait_state", o_state, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("init_done_state", o_state, 2);
    repeat (3) tick();
    checkOutput("init_single_pulse", pulse_cnt, 1);

    // Record wins over play; stop beats pause.
    i_rec_addr = 8'd0;
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("recplay_state", o_state, 3);
    checkOutput("recplay_rec_clr", o_rec_clr, 1);
    checkOutput("recplay_play_en", o_play_en, 0);
    i_rec_addr = 8'd100;
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("stop_pause_state", o_state, 2);
    checkOutput("stop_pause_len", o_rec_len, 100);

    // Record 100 samples then play them to the end.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rec_cleared_len", o_rec_len, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("rec_len_100", o_rec_len, 100);
    i_play_addr = 8'd0;
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("play_state", o_state, 5);
    checkOutput("play_en", o_play_en, 1);
    checkOutput("play_clr", o_play_clr, 1);
    i_play_addr = 8'd100;
    tick();
    checkOutput("play_done_pulse", o_play_done, 1);
    checkOutput("play_done_state", o_state, 2);
    tick();
    checkOutput("play_done_once", o_play_done, 0);

    // Pause/resume sequences for both directions.
    i_rec_addr = 8'd0;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("pause1_state", o_state, 4);
    checkOutput("pause1_rec_en", o_rec_en, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("resume_state", o_state, 3);
    checkOutput("resume_rec_en", o_rec_en, 1);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("pause2_state", o_state, 4);
    i_rec_addr = 8'd50;
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("paused_stop_len", o_rec_len, 50);
    i_play_addr = 8'd0;
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("play_pause_state", o_state, 6);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("play_pause_rec_ignored", o_state, 6);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("play_resume_state", o_state, 5);

    // Mid-play reset drops the enable and forgets the recording.
    #2 i_rst_n = 0;
    #1;
    checkOutput("rst_mid_play_en", o_play_en, 0);
    checkOutput("rst_mid_play_len", o_rec_len, 0);
    checkOutput("rst_mid_play_state", o_state, 0);
    tick();
    i_rst_n = 1;
    tick();
    applyStimulus(0, 0, 0, 0, 1);

    // Empty recording blocks play; full buffer auto-stops.
    i_rec_addr = 8'd0;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("empty_play_state", o_state, 2);
    checkOutput("empty_play_clr", o_play_clr, 0);
    applyStimulus(1, 0, 0, 0, 0);
    i_rec_addr = 8'hFF;
    tick();
    checkOutput("autostop_state", o_state, 2);
    checkOutput("autostop_len", o_rec_len, 255);

    // Mid-record reset.
    i_rec_addr = 8'd0;
    applyStimulus(1, 0, 0, 0, 0);
    #2 i_rst_n = 0;
    #1;
    checkOutput("rst_mid_rec_en", o_rec_en, 0);
    tick();
    i_rst_n = 1;
    tick();
    applyStimulus(0, 0, 0, 0, 1);

    // Randomized keys with a simple recorder/player address model.
    for (int i = 0; i < 3000; i++) begin
      i_key_rec   = ($urandom_range(0, 9) == 0);
      i_key_play  = ($urandom_range(0, 9) == 0);
      i_key_pause = ($urandom_range(0, 9) == 0);
      i_key_stop  = ($urandom_range(0, 11) == 0);
      i_init_finished = ($urandom_range(0, 5) == 0);
      if (o_rec_clr) i_rec_addr = '0;
      else if (o_rec_en) begin
        if ($urandom_range(0, 99) == 0) i_rec_addr = 8'hFF;
        else i_rec_addr = ADDR_W'((int'(i_rec_addr) + $urandom_range(0, 12) > ALL_ONES) ?
                                  ALL_ONES : int'(i_rec_addr) + $urandom_range(0, 12));
      end
      if (o_play_clr) i_play_addr = '0;
      else if (o_play_en)
        i_play_addr = ADDR_W'((int'(i_play_addr) + 8 > ALL_ONES) ? ALL_ONES :
                              int'(i_play_addr) + $urandom_range(0, 8));
      if ($urandom_range(0, 499) == 0) begin
        #2 i_rst_n = 0;
        tick();
        i_rst_n = 1;
      end else begin
        tick();
      end
    end
    i_key_rec = 0; i_key_play = 0; i_key_pause = 0; i_key_stop = 0; i_init_finished = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_seq_ctrl.md
AUDIO_SEQ_CTRL -- requirements
Module: audio_seq_ctrl

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 20, width of the audio sample address.
- INIT_TIMEOUT, 1048576, cycles to wait for codec init before retrying.
- MAX_RETRY, 3, number of init attempts before declaring an error.
REQ-002 Ports SHALL be:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_key_rec  in  1  one-cycle record request pulse.
- i_key_play  in  1  one-cycle play request pulse.
- i_key_pause  in  1  one-cycle pause/resume toggle pulse.
- i_key_stop  in  1  one-cycle stop request pulse.
- i_init_finished  in  1  one-cycle pulse from the codec I2C initializer.
- i_rec_addr  in  ADDR_W  current recorder write address.
- i_play_addr  in  ADDR_W  current player read address.
- o_init_start  out  1  one-cycle pulse that starts codec initialization.
- o_rec_en  out  1  recorder enable.
- o_rec_clr  out  1  one-cycle pulse that clears the recorder address.
- o_play_en  out  1  player enable.
- o_play_clr  out  1  one-cycle pulse that clears the player address.
- o_play_done  out  1  one-cycle pulse at the natural end of playback.
- o_rec_len  out  ADDR_W  latched recorded length.
- o_state  out  3  current state encoding.
- o_error  out  1  sticky init-failure flag.

Function
REQ-003 State encodings SHALL be: INIT_REQ=0, INIT_WAIT=1, IDLE=2, REC=3, REC_PAUSE=4, PLAY=5, PLAY_PAUSE=6, ERROR=7.
REQ-004 All outputs SHALL be registered; a key pulse sampled in cycle N SHALL change state and outputs in cycle N+1.
REQ-005 INIT_REQ SHALL assert o_init_start for exactly one cycle, clear the timeout counter, and go to INIT_WAIT.
REQ-006 INIT_WAIT SHALL increment the timeout counter each cycle and go to IDLE when i_init_finished=1.
REQ-007 In INIT_WAIT, when the counter reaches INIT_TIMEOUT-1 without i_init_finished, the block SHALL increment the retry count and return to INIT_REQ, or go to ERROR if the retry count equals MAX_RETRY-1.
REQ-008 If i_init_finished and the timeout occur in the same cycle, i_init_finished SHALL win.
REQ-009 ERROR SHALL hold o_error=1 with all enables low, ignore all keys, and be exited only by reset.
REQ-010 All keys SHALL be ignored in INIT_REQ and INIT_WAIT.
REQ-011 IDLE with i_key_rec SHALL pulse o_rec_clr for one cycle, clear o_rec_len to 0, and go to REC.
REQ-012 IDLE with i_key_play SHALL pulse o_play_clr and go to PLAY only if o_rec_len != 0; otherwise the key SHALL be ignored.
REQ-013 In IDLE, if i_key_rec and i_key_play arrive together, record SHALL win; i_key_pause and i_key_stop SHALL be no-ops.
REQ-014 REC SHALL hold o_rec_en=1.
REQ-015 REC with i_key_stop, or with i_rec_addr equal to all-ones, SHALL latch o_rec_len=i_rec_addr and go to IDLE.
REQ-016 REC with i_key_pause SHALL go to REC_PAUSE; stop SHALL take priority over pause.
REQ-017 REC_PAUSE SHALL hold o_rec_en=0, return to REC on i_key_pause or i_key_rec, and on i_key_stop latch o_rec_len=i_rec_addr and go to IDLE.
REQ-018 PLAY SHALL hold o_play_en=1 and, when i_play_addr >= o_rec_len, pulse o_play_done and go to IDLE.
REQ-019 PLAY with i_key_stop SHALL go to IDLE without pulsing o_play_done; stop SHALL take priority over end-of-data and pause.
REQ-020 PLAY with i_key_pause SHALL go to PLAY_PAUSE.
REQ-021 PLAY_PAUSE SHALL hold o_play_en=0, return to PLAY on i_key_pause or i_key_play, and go to IDLE on i_key_stop.
REQ-022 i_key_rec SHALL be ignored in PLAY and PLAY_PAUSE, and i_key_play SHALL be ignored in REC and REC_PAUSE.
REQ-023 o_rec_en and o_play_en SHALL never be high in the same cycle.
REQ-024 The timeout counter SHALL be sized to hold INIT_TIMEOUT-1 without wrap, and the retry counter SHALL saturate and never wrap.

Reset
REQ-025 On i_rst_n=0 the block SHALL asynchronously enter INIT_REQ with all counters 0, o_rec_len=0, o_error=0, and all other outputs 0.
REQ-026 On the first clock edge after reset release, o_init_start SHALL be 1.
REQ-027 Reset asserted mid-REC or mid-PLAY SHALL drop o_rec_en and o_play_en immediately, and recorded length SHALL be lost.

Verification
REQ-028 Release reset and pulse i_init_finished 10 cycles after o_init_start -> o_state goes 0,1,2 and o_init_start pulses exactly once.
REQ-029 With INIT_TIMEOUT=16 and MAX_RETRY=3, never pulse i_init_finished -> o_init_start pulses 3 times 16 cycles apart, then o_state=7 and o_error=1 persist and keys are ignored.
REQ-030 From IDLE: i_key_rec, drive i_rec_addr to 100, i_key_stop, i_key_play, drive i_play_addr to 100 -> o_rec_len=100, o_play_en high, then one o_play_done pulse and o_state=2.
REQ-031 Pulse i_key_rec and i_key_play in the same cycle in IDLE -> REC entered, o_rec_clr pulses, o_play_en stays 0.
REQ-032 In REC, pulse i_key_pause and i_key_stop in the same cycle -> IDLE with o_rec_len latched; a separate pause, resume, pause sequence -> o_state 3,4,3,4 with o_rec_en following.
REQ-033 In IDLE with o_rec_len=0, pulse i_key_play -> stays IDLE and no o_play_clr pulse; in REC, drive i_rec_addr to all-ones -> auto-stop with o_rec_len all-ones.
